alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Decodes add/sub/slt/addi/slti/beq, drives an external ALU for
//           SETTLE_CYCLES and holds the captured result until consumed.
//           Optional overflow trap: define ALU_ISSUE_OVF_TRAP_EN.
// Rev     : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    input  logic [4:0]  shamt,
    input  logic [31:0] pc_plus4,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        ovf_exc
);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_slt   = 6'h2A;
    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_slt  = 4'b1000;
    localparam logic [2:0] c_cnt_last = 3'(SETTLE_CYCLES - 1);

`ifdef ALU_ISSUE_OVF_TRAP_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2,
        S_EXC   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [31:0] r_alu_data1;
    logic [31:0] r_alu_data2;
    logic [3:0]  r_alu_ctrl;
    logic [4:0]  r_alu_shamt;
    logic [31:0] r_branch_target;
    logic        r_is_beq;
    logic [31:0] r_out_result;
    logic        r_branch_taken;
    logic        r_out_valid;

    logic        w_legal;
    logic [3:0]  w_ctrl;
    logic        w_use_imm;
    logic        w_is_beq;
    logic        w_ovf_op;
    logic [31:0] w_sext_imm;
    logic [31:0] w_branch_tgt;
    logic        w_accept;
    logic        w_capture;
    logic        w_trap;

    assign w_sext_imm   = {{16{imm[15]}}, imm};
    assign w_branch_tgt = pc_plus4 + {w_sext_imm[29:0], 2'b00};

    always_comb begin
        w_legal   = 1'b1;
        w_ctrl    = c_alu_add;
        w_use_imm = 1'b0;
        w_is_beq  = 1'b0;
        w_ovf_op  = 1'b0;
        case (opcode)
            c_op_rtype: begin
                case (funct)
                    c_fn_add: begin w_ctrl = c_alu_add; w_ovf_op = 1'b1; end
                    c_fn_sub: begin w_ctrl = c_alu_sub; w_ovf_op = 1'b1; end
                    c_fn_slt: w_ctrl = c_alu_slt;
                    default:  w_legal = 1'b0;
                endcase
            end
            c_op_addi: begin w_ctrl = c_alu_add; w_use_imm = 1'b1; w_ovf_op = 1'b1; end
            c_op_slti: begin w_ctrl = c_alu_slt; w_use_imm = 1'b1; end
            c_op_beq:  begin w_ctrl = c_alu_sub; w_is_beq = 1'b1; end
            default:   w_legal = 1'b0;
        endcase
    end

`ifdef ALU_ISSUE_OVF_TRAP_EN
    logic r_ovf_op;
    assign w_trap  = r_ovf_op & alu_overflow;
    assign ovf_exc = (r_state == S_EXC);
`else
    logic w_unused_ok;
    assign w_unused_ok = alu_overflow ^ w_ovf_op;
    assign w_trap      = 1'b0;
    assign ovf_exc     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_legal ? S_DRIVE : S_HOLD;
                end
            end
            S_DRIVE: begin
                if (r_cnt == c_cnt_last) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
`ifdef ALU_ISSUE_OVF_TRAP_EN
                    if (w_trap) w_state_nxt = S_EXC;
`endif
                end
            end
            S_HOLD: begin
                if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
            end
`ifdef ALU_ISSUE_OVF_TRAP_EN
            S_EXC:   w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // out_valid rises one cycle after HOLD is entered, giving a fixed publish stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt           <= '0;
            r_alu_data1     <= '0;
            r_alu_data2     <= '0;
            r_alu_ctrl      <= '0;
            r_alu_shamt     <= '0;
            r_branch_target <= '0;
            r_is_beq        <= 1'b0;
            r_out_result    <= '0;
            r_branch_taken  <= 1'b0;
            r_out_valid     <= 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
            r_ovf_op        <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_alu_data1     <= rs_val;
                r_alu_data2     <= w_use_imm ? w_sext_imm : rt_val;
                r_alu_ctrl      <= w_ctrl;
                r_alu_shamt     <= shamt;
                r_branch_target <= w_is_beq ? w_branch_tgt : 32'h0;
                r_is_beq        <= w_is_beq;
                r_cnt           <= '0;
                r_out_result    <= '0;
                r_branch_taken  <= 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
                r_ovf_op        <= w_ovf_op;
`endif
            end else if (r_state == S_DRIVE && !w_capture) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_capture) begin
                r_out_result   <= w_trap ? 32'h0 : alu_result;
                r_branch_taken <= r_is_beq & alu_zero & ~w_trap;
            end
            if (r_state == S_HOLD && !r_out_valid) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign alu_data1     = r_alu_data1;
    assign alu_data2     = r_alu_data2;
    assign alu_ctrl      = r_alu_ctrl;
    assign alu_shamt     = r_alu_shamt;
    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign branch_taken  = r_branch_taken;
    assign branch_target = r_branch_target;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_ctrl
// Brief   : Directed + random stimulus with a queue scoreboard and an ALU model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int    SETTLE = 1;
    localparam longint MAXI  = 64'sd2147483647;
    localparam longint MINI  = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [15:0] imm = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] pc_plus4 = '0;
    logic [31:0] alu_data1, alu_data2;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ovf_exc;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .shamt(shamt), .pc_plus4(pc_plus4),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl),
        .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .branch_taken(branch_taken),
        .branch_target(branch_target), .ovf_exc(ovf_exc)
    );

    // External ALU; noise is injected while a result is held so late sampling shows up
    logic [31:0] noise = '0;
    longint      alu_wide;
    always @(posedge clk) noise <= $urandom();
    always_comb begin
        alu_wide = 0;
        case (alu_ctrl)
            4'b0000: alu_wide = longint'($signed(alu_data1)) + longint'($signed(alu_data2));
            4'b0001: alu_wide = longint'($signed(alu_data1)) - longint'($signed(alu_data2));
            4'b1000: alu_wide = ($signed(alu_data1) < $signed(alu_data2)) ? 1 : 0;
            default: alu_wide = 0;
        endcase
        alu_result   = alu_wide[31:0] ^ (out_valid ? noise : 32'h0);
        alu_zero     = (alu_wide[31:0] == 32'h0) ^ (out_valid & noise[0]);
        alu_overflow = ((alu_ctrl != 4'b1000) && (alu_wide > MAXI || alu_wide < MINI))
                       ^ (out_valid & noise[1]);
    end

    typedef struct {
        logic [31:0] res;
        logic        taken;
        logic [31:0] tgt;
        logic        beq;
        logic        exc;
        logic        ovfk;
        int          lat;
        int          acc;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [15:0] im, input logic [31:0] pc);
        exp_t   e;
        longint a, b, bi, r;
        bit     legal;
        e     = '{default: 0};
        a     = longint'($signed(rs));
        b     = longint'($signed(rt));
        bi    = longint'($signed(im));
        r     = 0;
        legal = 1;
        if (op == 6'h00 && fn == 6'h20)      begin r = a + b; e.ovfk = 1; end
        else if (op == 6'h00 && fn == 6'h22) begin r = a - b; e.ovfk = 1; end
        else if (op == 6'h00 && fn == 6'h2A) r = (a < b) ? 1 : 0;
        else if (op == 6'h08)                begin r = a + bi; e.ovfk = 1; end
        else if (op == 6'h0A)                r = (a < bi) ? 1 : 0;
        else if (op == 6'h04) begin
            r       = a - b;
            e.beq   = 1;
            e.taken = (rs == rt);
            e.tgt   = pc + 32'(bi * 4);
        end else legal = 0;
        e.res = legal ? r[31:0] : 32'h0;
        e.lat = legal ? SETTLE + 1 : 1;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        e.exc = e.ovfk && (r > MAXI || r < MINI);
        if (e.exc) begin
            e.res   = 0;
            e.lat   = SETTLE;
        end
`endif
        return e;
    endfunction

    // Monitor: pops on each new result or exception pulse, checks stability while held
    exp_t        m_e;
    bit          seen = 0;
    bit          prev_exc = 0;
    logic [31:0] s_res, s_tgt;
    logic        s_tk;
    always @(negedge clk) begin
        if (!reset) begin
            seen      = 0;
            prev_exc  = 0;
            out_ready = 1'b0;
        end else begin
            if (out_valid) begin
                if (!seen) begin
                    if (expq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out_valid actual=1 required=0");
                    end else begin
                        m_e = expq.pop_front();
                        chk("out_result", 64'(out_result), 64'(m_e.res));
                        chk("branch_taken", 64'(branch_taken), 64'(m_e.taken));
                        if (m_e.beq) chk("branch_target", 64'(branch_target), 64'(m_e.tgt));
                        chk("latency", 64'(cyc - m_e.acc), 64'(m_e.lat));
                        chk("ovf_exc_with_valid", 64'(ovf_exc), 64'(m_e.exc));
                    end
                    seen  = 1;
                    s_res = out_result;
                    s_tgt = branch_target;
                    s_tk  = branch_taken;
                end else begin
                    chk("hold_result", 64'(out_result), 64'(s_res));
                    chk("hold_taken", 64'(branch_taken), 64'(s_tk));
                    chk("hold_target", 64'(branch_target), 64'(s_tgt));
                    chk("hold_in_ready", 64'(in_ready), 64'(0));
                end
            end
            if (ovf_exc) begin
                chk("ovf_exc_one_cycle", 64'(prev_exc), 64'(0));
                if (!prev_exc) begin
                    if (expq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_ovf_exc actual=1 required=0");
                    end else begin
                        m_e = expq.pop_front();
                        chk("ovf_exc_expected", 64'(ovf_exc), 64'(m_e.exc));
                        chk("exc_latency", 64'(cyc - m_e.acc), 64'(m_e.lat));
                        chk("exc_no_valid", 64'(out_valid), 64'(0));
                    end
                end
            end
            prev_exc = ovf_exc;
            if (stall > 0) begin
                out_ready = 1'b0;
                if (out_valid) stall--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid && out_ready) seen = 0;
        end
    end

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] im, input logic [31:0] pc);
        exp_t e;
        int   w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL in_ready_timeout actual=0 required=1");
            return;
        end
        opcode   = op;
        funct    = fn;
        rs_val   = rs;
        rt_val   = rt;
        imm      = im;
        shamt    = 5'($urandom());
        pc_plus4 = pc;
        in_valid = 1'b1;
        e        = ref_model(op, fn, rs, rt, im, pc);
        e.acc    = cyc + 1;
        expq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        rs_val   = $urandom();
        rt_val   = $urandom();
        imm      = 16'($urandom());
        pc_plus4 = $urandom();
    endtask

    initial begin
        logic [5:0]  op, fn;
        logic [31:0] rs, rt;
        int          sel, w;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_alu_regs", 64'({alu_data1, alu_data2} | 64'({alu_ctrl, alu_shamt})), 64'(0));
        chk("rst_outputs", 64'({out_result, branch_target} | 64'({branch_taken, ovf_exc})), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        issue(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 32'h40);
        chk("add_alu_ctrl", 64'(alu_ctrl), 64'(4'b0000));
        chk("add_alu_ops", 64'({alu_data1, alu_data2}), {32'd5, 32'd7});

        issue(6'h04, 6'h00, 32'd9, 32'd9, 16'h0003, 32'h100);
        issue(6'h04, 6'h00, 32'd9, 32'd8, 16'h0003, 32'h100);
        issue(6'h08, 6'h00, 32'h7FFF_FFFF, 32'h0, 16'h0001, 32'h0);

        stall = 5;
        issue(6'h0A, 6'h00, 32'hFFFF_FFFD, 32'h0, 16'hFFFE, 32'h0);
        chk("slti_alu_data2", 64'(alu_data2), 64'(32'hFFFF_FFFE));

        issue(6'h23, 6'h00, 32'h1234, 32'h5678, 16'h10, 32'h200);

        issue(6'h00, 6'h22, 32'd20, 32'd3, 16'h0, 32'h0);
        reset = 1'b0;
        expq.delete();
        #1;
        chk("mid_rst_alu", 64'({alu_data1, alu_data2} | 64'({alu_ctrl, alu_shamt})), 64'(0));
        chk("mid_rst_out", 64'({out_result, branch_target} | 64'({out_valid, branch_taken, ovf_exc})), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        issue(6'h00, 6'h20, 32'd1, 32'd1, 16'h0, 32'h0);

        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 7);
            rs  = $urandom();
            rt  = ($urandom_range(0, 3) == 0) ? rs : $urandom();
            if ($urandom_range(0, 4) == 0) rs = 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
            fn  = 6'h00;
            case (sel)
                0: begin op = 6'h00; fn = 6'h20; end
                1: begin op = 6'h00; fn = 6'h22; end
                2: begin op = 6'h00; fn = 6'h2A; end
                3: op = 6'h08;
                4: op = 6'h0A;
                5: op = 6'h04;
                6: begin
                    op = 6'($urandom_range(1, 63));
                    if (op == 6'h08 || op == 6'h0A || op == 6'h04) op = 6'h23;
                end
                default: begin
                    op = 6'h00;
                    fn = 6'($urandom_range(0, 63));
                    if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) fn = 6'h25;
                end
            endcase
            issue(op, fn, rs, rt, 16'($urandom()), $urandom() & 32'hFFFF_FFFC);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        w = 0;
        while (expq.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("queue_drained", 64'(expq.size()), 64'(0));
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        total++;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
